// File: rtl/uart_frame_sender.sv
// Frame streamer: fetches pixels one at a time and sends them MSB-first as bytes to a UART TX core,
// optionally preceded by a 6-byte size header and followed by an XOR checksum of the payload.
module uart_frame_sender #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned PIX_W  = 10,
    parameter int unsigned BPP    = 3,
    parameter int unsigned HEADER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             pix_rd,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic             tx_done,
    output logic             busy,
    output logic             done,
    output logic [15:0]      cur_x,
    output logic [15:0]      cur_y
);
    localparam int unsigned SR_W   = 8 * BPP;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BIDX_W = 2;
    localparam int unsigned HIDX_W = 3;
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [15:0]       W16      = 16'(WIDTH);
    localparam logic [15:0]       H16      = 16'(HEIGHT);
    localparam logic [BIDX_W-1:0] LAST_B   = BIDX_W'(BPP - 1);

    if (PIX_W > SR_W) begin : g_pix_w_check
        $error("uart_frame_sender: PIX_W must not exceed 8*BPP");
    end

    typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT_PIX, BYTE, WAIT_TX, CSUM, FIN} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_PIX, PH_CSUM} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [HIDX_W-1:0]  hdr_idx_q, hdr_idx_d;
    logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [SR_W-1:0]    sreg_q, sreg_d;
    logic [7:0]         csum_q, csum_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [15:0]        cur_x_d, cur_y_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d, pix_rd_d, busy_d, done_d;

    function automatic logic [7:0] hdr_byte(input logic [HIDX_W-1:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'hA5;
            3'd1:    hdr_byte = 8'h5A;
            3'd2:    hdr_byte = W16[15:8];
            3'd3:    hdr_byte = W16[7:0];
            3'd4:    hdr_byte = H16[15:8];
            default: hdr_byte = H16[7:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_HDR;
            hdr_idx_q  <= '0;
            byte_idx_q <= '0;
            sreg_q     <= '0;
            csum_q     <= '0;
            pix_cnt_q  <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            pix_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hdr_idx_q  <= hdr_idx_d;
            byte_idx_q <= byte_idx_d;
            sreg_q     <= sreg_d;
            csum_q     <= csum_d;
            pix_cnt_q  <= pix_cnt_d;
            cur_x      <= cur_x_d;
            cur_y      <= cur_y_d;
            tx_data    <= tx_data_d;
            tx_start   <= tx_start_d;
            pix_rd     <= pix_rd_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hdr_idx_d  = hdr_idx_q;
        byte_idx_d = byte_idx_q;
        sreg_d     = sreg_q;
        csum_d     = csum_q;
        pix_cnt_d  = pix_cnt_q;
        cur_x_d    = cur_x;
        cur_y_d    = cur_y;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = (HEADER != 0) ? HDR : FETCH;
            end
            HDR: begin
                if (!tx_busy) begin
                    tx_data_d  = hdr_byte(hdr_idx_q);
                    tx_start_d = 1'b1;
                    phase_d    = PH_HDR;
                    state_d    = WAIT_TX;
                end
            end
            FETCH: state_d = WAIT_PIX;
            WAIT_PIX: begin
                if (pix_valid) begin
                    sreg_d     = SR_W'(pix_data);
                    byte_idx_d = '0;
                    state_d    = BYTE;
                end
            end
            BYTE: begin
                if (!tx_busy) begin
                    tx_data_d  = sreg_q[SR_W-1 -: 8];
                    csum_d     = csum_q ^ sreg_q[SR_W-1 -: 8];
                    tx_start_d = 1'b1;
                    phase_d    = PH_PIX;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // A done pulse coincident with our own tx_start belongs to an older byte.
                if (tx_done && !tx_start) begin
                    case (phase_q)
                        PH_HDR: begin
                            if (hdr_idx_q == HIDX_W'(5)) begin
                                state_d = FETCH;
                            end else begin
                                hdr_idx_d = hdr_idx_q + HIDX_W'(1);
                                state_d   = HDR;
                            end
                        end
                        PH_PIX: begin
                            if (byte_idx_q == LAST_B) begin
                                pix_cnt_d = pix_cnt_q + CNT_W'(1);
                                if (cur_x == W16 - 16'd1) begin
                                    cur_x_d = '0;
                                    cur_y_d = cur_y + 16'd1;
                                end else begin
                                    cur_x_d = cur_x + 16'd1;
                                end
                                state_d = (pix_cnt_q == LAST_PIX) ? CSUM : FETCH;
                            end else begin
                                byte_idx_d = byte_idx_q + BIDX_W'(1);
                                sreg_d     = sreg_q << 8;
                                state_d    = BYTE;
                            end
                        end
                        default: state_d = FIN;
                    endcase
                end
            end
            CSUM: begin
                if (!tx_busy) begin
                    tx_data_d  = csum_q;
                    tx_start_d = 1'b1;
                    phase_d    = PH_CSUM;
                    state_d    = WAIT_TX;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;

        // Entering IDLE (normally or by abort) puts everything back to its reset value.
        if (state_d == IDLE) begin
            phase_d    = PH_HDR;
            hdr_idx_d  = '0;
            byte_idx_d = '0;
            sreg_d     = '0;
            csum_d     = '0;
            pix_cnt_d  = '0;
            cur_x_d    = '0;
            cur_y_d    = '0;
            tx_data_d  = '0;
            tx_start_d = 1'b0;
        end

        pix_rd_d = (state_d == FETCH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
    end
endmodule
